cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 13 +
 rtl/retire_counter.sv | 19 +
 rtl/cpu_sequencer.sv | 103 ++++++++++
 tb/tb_cpu_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer and the instruction decoder.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_IDLE  = 2'b11
  } state_t;

  localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: synchronous clear, count enable, silent wrap.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Phase sequencer for a multi-cycle CPU: fetch/execute FSM with run, single-step
// and halt/resume control, plus a retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instruction,
  input  logic             sm_extra,
  input  logic             run_en,
  input  logic             step_req,
  input  logic             resume,
  output logic [1:0]       state,
  output logic             retire,
  output logic             step_ack,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  state_t state_q;
  state_t state_d;
  state_t after_retire;
  logic   step_pending;
  logic   go;
  logic   is_halt;
  logic   retire_fsm;
  logic   unused_operand;

  assign unused_operand = ^instruction[11:0];

  assign go      = (run_en | step_pending) & ~halted;
  assign is_halt = (instruction[15:12] == HALT_OPCODE);

  // Halt takes precedence over step, which takes precedence over free-run.
  always_comb begin
    after_retire = ST_IDLE;
    if (!is_halt && !step_pending && run_en) begin
      after_retire = ST_FETCH;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire_fsm = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (go) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (sm_extra) begin
          state_d = ST_EXEC2;
        end else begin
          retire_fsm = 1'b1;
          state_d    = after_retire;
        end
      end
      ST_EXEC2: begin
        retire_fsm = 1'b1;
        state_d    = after_retire;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An instruction interrupted by reset never reports a retire.
  assign retire   = retire_fsm & ~reset;
  assign step_ack = retire & step_pending;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      halted       <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      state_q <= state_d;

      if (retire && is_halt) begin
        halted <= 1'b1;
      end else if (resume && halted) begin
        halted <= 1'b0;
      end

      if (step_ack) begin
        step_pending <= 1'b0;
      end else if (step_req && (state_q == ST_IDLE) && !run_en && !halted) begin
        step_pending <= 1'b1;
      end
    end
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk    (clk),
    .clear  (reset),
    .enable (retire),
    .count  (retired_count)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-vector bench for cpu_sequencer, plus a narrow-counter instance for wrap.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        sm_extra, run_en, step_req, resume;
  logic [1:0]  state;
  logic        retire, step_ack, halted;
  logic [15:0] retired_count;

  logic        w_reset, w_run;
  logic [1:0]  w_state;
  logic        w_retire, w_step_ack, w_halted;
  logic [3:0]  w_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.HALT_OPCODE(4'hF), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .sm_extra(sm_extra),
    .run_en(run_en), .step_req(step_req), .resume(resume), .state(state),
    .retire(retire), .step_ack(step_ack), .halted(halted),
    .retired_count(retired_count)
  );

  cpu_sequencer #(.HALT_OPCODE(4'hF), .CNT_W(4)) dut_wrap (
    .clk(clk), .reset(w_reset), .instruction(16'h1234), .sm_extra(1'b0),
    .run_en(w_run), .step_req(1'b0), .resume(1'b0), .state(w_state),
    .retire(w_retire), .step_ack(w_step_ack), .halted(w_halted),
    .retired_count(w_count)
  );

  typedef struct {
    logic        rst, run, step, res, extra;
    logic [15:0] instr;
    logic        chk;
    logic [1:0]  st;
    logic        ret, ack, hlt;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, run, step, res, extra, input logic [15:0] instr,
                     input logic chk, input logic [1:0] st, input logic ret, ack, hlt,
                     input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.run = run; v.step = step; v.res = res; v.extra = extra;
    v.instr = instr; v.chk = chk; v.st = st; v.ret = ret; v.ack = ack;
    v.hlt = hlt; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; run_en = 1'b0; step_req = 1'b0; resume = 1'b0;
    sm_extra = 1'b0; instruction = 16'h1234;
    w_reset = 1'b1; w_run = 1'b0;

    //  rst run stp res ext instr    chk st ret ack hlt cnt
    add(1, 1, 0, 0, 0, 16'h1234, 0, 3, 0, 0, 0, 0);   // reset cycle
    add(0, 1, 0, 0, 0, 16'h1234, 1, 3, 0, 0, 0, 0);   // free run
    add(0, 1, 0, 0, 0, 16'h1234, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h1234, 1, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h1234, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 16'h1234, 1, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 16'h1234, 1, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 16'h1234, 1, 1, 1, 0, 0, 2);
    add(0, 1, 0, 0, 0, 16'h1234, 1, 0, 0, 0, 0, 3);
    add(0, 1, 0, 0, 0, 16'h1234, 1, 1, 1, 0, 0, 3);
    add(0, 1, 0, 0, 0, 16'h1234, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 0, 16'h1234, 1, 1, 1, 0, 0, 4);
    add(0, 1, 0, 0, 1, 16'h1234, 1, 0, 0, 0, 0, 5);   // extra cycle
    add(0, 1, 0, 0, 1, 16'h1234, 1, 1, 0, 0, 0, 5);
    add(0, 1, 0, 0, 1, 16'h1234, 1, 2, 1, 0, 0, 5);
    add(0, 1, 0, 0, 1, 16'h1234, 1, 0, 0, 0, 0, 6);   // sm_extra ignored in FETCH
    add(0, 0, 0, 0, 0, 16'h1234, 1, 1, 1, 0, 0, 6);   // run_en falls in EXEC
    add(0, 0, 1, 0, 0, 16'h1234, 1, 3, 0, 0, 0, 7);   // step request
    add(0, 0, 0, 0, 1, 16'h1234, 1, 3, 0, 0, 0, 7);
    add(0, 0, 0, 0, 1, 16'h1234, 1, 0, 0, 0, 0, 7);
    add(0, 0, 1, 0, 1, 16'h1234, 1, 1, 0, 0, 0, 7);   // step_req in EXEC ignored
    add(0, 0, 1, 0, 0, 16'h1234, 1, 2, 1, 1, 0, 7);   // step_req at step retire ignored
    add(0, 0, 0, 0, 0, 16'h1234, 1, 3, 0, 0, 0, 8);
    add(0, 0, 0, 0, 0, 16'h1234, 1, 3, 0, 0, 0, 8);
    add(0, 1, 0, 0, 0, 16'hF000, 1, 3, 0, 0, 0, 8);   // halt
    add(0, 1, 0, 0, 0, 16'hF000, 1, 0, 0, 0, 0, 8);
    add(0, 1, 0, 0, 0, 16'hF000, 1, 1, 1, 0, 0, 8);
    add(0, 1, 0, 0, 0, 16'hF000, 1, 3, 0, 0, 1, 9);
    add(0, 1, 1, 0, 0, 16'hF000, 1, 3, 0, 0, 1, 9);
    add(0, 1, 0, 1, 0, 16'h1234, 1, 3, 0, 0, 1, 9);   // resume
    add(0, 1, 0, 1, 0, 16'h1234, 1, 3, 0, 0, 0, 9);   // resume while not halted
    add(0, 1, 0, 0, 0, 16'h1234, 1, 0, 0, 0, 0, 9);
    add(0, 1, 0, 0, 0, 16'h1234, 1, 1, 1, 0, 0, 9);
    add(0, 1, 0, 0, 1, 16'h1234, 1, 0, 0, 0, 0, 10);
    add(0, 1, 0, 0, 1, 16'h1234, 1, 1, 0, 0, 0, 10);
    add(1, 1, 0, 0, 1, 16'h1234, 1, 2, 0, 0, 0, 10);  // reset in EXEC2
    add(0, 0, 0, 0, 0, 16'h1234, 1, 3, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 16'h1234, 1, 3, 0, 0, 0, 0);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; run_en = vecs[i].run; step_req = vecs[i].step;
      resume = vecs[i].res; sm_extra = vecs[i].extra; instruction = vecs[i].instr;
      #1;
      if (vecs[i].chk) begin
        check("state", i, 32'(state), 32'(vecs[i].st));
        check("retire", i, 32'(retire), 32'(vecs[i].ret));
        check("step_ack", i, 32'(step_ack), 32'(vecs[i].ack));
        check("halted", i, 32'(halted), 32'(vecs[i].hlt));
        check("retired_count", i, 32'(retired_count), 32'(vecs[i].cnt));
      end
      @(posedge clk); #1;
    end
    reset = 1'b1; run_en = 1'b0; step_req = 1'b0; resume = 1'b0;

    // Counter wrap on a 4-bit instance: 15 retires reach all-ones, the 16th wraps.
    w_reset = 1'b1; w_run = 1'b1;
    @(posedge clk); #1;
    w_reset = 1'b0;
    check("wrap_idle_state", 0, 32'(w_state), 32'd3);
    check("wrap_reset_count", 0, 32'(w_count), 32'd0);
    for (int c = 0; c < 31; c++) begin
      @(posedge clk); #1;
    end
    check("wrap_all_ones", 31, 32'(w_count), 32'hF);
    @(posedge clk); #1;
    check("wrap_retire", 32, 32'(w_retire), 32'd1);
    @(posedge clk); #1;
    check("wrap_zero", 33, 32'(w_count), 32'd0);
    check("wrap_halted", 33, 32'(w_halted), 32'd0);
    check("wrap_step_ack", 33, 32'(w_step_ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
